// File: rtl/stopwatch_sequencer.sv
// Stopwatch control sequencer: turns debounced button/switch levels and divider tick strobes
// into one-cycle clear/increment commands for the MM:SS counter plus display mode flags.
// Everything runs on clk; the ticks are clock enables, not derived clocks.
// Optional lap/freeze display hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_sequencer #(
   parameter bit          AUTO_START = 1'b0,
   parameter int unsigned ADJ_DIV    = 1,
   parameter int unsigned BLINK_DIV  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       reset_btn,
   input  logic       pause_btn,
   input  logic       sel,
   input  logic       adj,
   input  logic       tick_run,
   input  logic       tick_adj,
   input  logic       tick_blink,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap_btn,
   output logic       freeze,
`endif
   output logic       clr,
   output logic       inc_sec,
   output logic       inc_min,
   output logic       adj_mode,
   output logic       blink,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StRun    = 2'b01,
      StPaused = 2'b10,
      StAdjust = 2'b11
   } state_e;

   localparam state_e      RESET_STATE = AUTO_START ? StRun : StIdle;
   localparam logic [3:0] ADJ_LAST    = 4'(ADJ_DIV - 1);
   localparam logic [3:0] BLINK_LAST  = 4'(BLINK_DIV - 1);

   state_e     state_q, state_d;
   logic       run_flag_q, run_flag_d;
   logic       reset_prev_q, pause_prev_q;
   logic [3:0] adj_cnt_q, adj_cnt_d;
   logic [3:0] blink_cnt_q, blink_cnt_d;
   logic       clr_q, clr_d;
   logic       inc_sec_q, inc_sec_d;
   logic       inc_min_q, inc_min_d;
   logic       adj_mode_q, adj_mode_d;
   logic       blink_q, blink_d;
   logic       reset_edge, pause_edge;

`ifdef STOPWATCH_LAP_EN
   logic       lap_prev_q;
   logic       freeze_q, freeze_d;
   logic       lap_edge;
`endif

   // Next-state and command decode; priority is reset_btn edge > adj level > pause edge > ticks.
   always_comb begin
      reset_edge  = reset_btn & ~reset_prev_q;
      pause_edge  = pause_btn & ~pause_prev_q;
      state_d     = state_q;
      run_flag_d  = run_flag_q;
      adj_cnt_d   = adj_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      clr_d       = 1'b0;
      inc_sec_d   = 1'b0;
      inc_min_d   = 1'b0;

      if (reset_edge) begin
         clr_d       = 1'b1;
         run_flag_d  = 1'b0;
         adj_cnt_d   = '0;
         blink_cnt_d = '0;
         blink_d     = 1'b1;
         state_d     = adj ? StAdjust : StIdle;
      end else if (adj) begin
         if (state_q != StAdjust) begin
            // Entering adjust: restart the increment divider and blink phase.
            state_d     = StAdjust;
            adj_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
         end else begin
            // run_flag remembers where to go when adjust ends.
            if (pause_edge) run_flag_d = ~run_flag_q;
            if (tick_adj) begin
               if (adj_cnt_q == ADJ_LAST) begin
                  adj_cnt_d = '0;
                  if (sel) inc_sec_d = 1'b1;
                  else     inc_min_d = 1'b1;
               end else begin
                  adj_cnt_d = adj_cnt_q + 4'd1;
               end
            end
            if (tick_blink) begin
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  blink_d     = ~blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + 4'd1;
               end
            end
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pause_edge) begin
                  state_d    = StRun;
                  run_flag_d = 1'b1;
               end
            end
            StRun: begin
               // A tick coinciding with pause still counts.
               if (tick_run) inc_sec_d = 1'b1;
               if (pause_edge) begin
                  state_d    = StPaused;
                  run_flag_d = 1'b0;
               end
            end
            StPaused: begin
               if (pause_edge) begin
                  state_d    = StRun;
                  run_flag_d = 1'b1;
               end
            end
            StAdjust: begin
               // A pause edge on the exit cycle still toggles the resume target.
               run_flag_d = run_flag_q ^ pause_edge;
               state_d    = run_flag_d ? StRun : StPaused;
               blink_d    = 1'b1;
            end
         endcase
      end

      adj_mode_d = (state_d == StAdjust);
   end

`ifdef STOPWATCH_LAP_EN
   // Freeze toggles on lap edges while staying in RUN; any other outcome clears it.
   always_comb begin
      lap_edge = lap_btn & ~lap_prev_q;
      freeze_d = freeze_q;
      if (state_d != StRun || reset_edge) begin
         freeze_d = 1'b0;
      end else if (state_q == StRun && lap_edge) begin
         freeze_d = ~freeze_q;
      end
   end
`endif

   // State and output registers; prev registers track inputs during reset to suppress edges.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= RESET_STATE;
         run_flag_q   <= AUTO_START;
         reset_prev_q <= reset_btn;
         pause_prev_q <= pause_btn;
         adj_cnt_q    <= '0;
         blink_cnt_q  <= '0;
         clr_q        <= 1'b0;
         inc_sec_q    <= 1'b0;
         inc_min_q    <= 1'b0;
         adj_mode_q   <= 1'b0;
         blink_q      <= 1'b1;
`ifdef STOPWATCH_LAP_EN
         lap_prev_q   <= lap_btn;
         freeze_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         run_flag_q   <= run_flag_d;
         reset_prev_q <= reset_btn;
         pause_prev_q <= pause_btn;
         adj_cnt_q    <= adj_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         clr_q        <= clr_d;
         inc_sec_q    <= inc_sec_d;
         inc_min_q    <= inc_min_d;
         adj_mode_q   <= adj_mode_d;
         blink_q      <= blink_d;
`ifdef STOPWATCH_LAP_EN
         lap_prev_q   <= lap_btn;
         freeze_q     <= freeze_d;
`endif
      end
   end

   assign clr      = clr_q;
   assign inc_sec  = inc_sec_q;
   assign inc_min  = inc_min_q;
   assign adj_mode = adj_mode_q;
   assign blink    = blink_q;
   assign state    = state_q;
`ifdef STOPWATCH_LAP_EN
   assign freeze   = freeze_q;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Table-driven bench for stopwatch_sequencer (AUTO_START=0, ADJ_DIV=2, BLINK_DIV=1).
// Each table row is one clock: inputs driven, then registered outputs checked after the edge.
module tb_stopwatch_sequencer;

   logic       clk = 1'b0;
   logic       reset_n, reset_btn, pause_btn, sel, adj, tick_run, tick_adj, tick_blink;
   logic       clr, inc_sec, inc_min, adj_mode, blink;
   logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
   logic       lap_btn, freeze;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stopwatch_sequencer #(
      .AUTO_START(1'b0),
      .ADJ_DIV   (2),
      .BLINK_DIV (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .reset_btn (reset_btn),
      .pause_btn (pause_btn),
      .sel       (sel),
      .adj       (adj),
      .tick_run  (tick_run),
      .tick_adj  (tick_adj),
      .tick_blink(tick_blink),
`ifdef STOPWATCH_LAP_EN
      .lap_btn   (lap_btn),
      .freeze    (freeze),
`endif
      .clr       (clr),
      .inc_sec   (inc_sec),
      .inc_min   (inc_min),
      .adj_mode  (adj_mode),
      .blink     (blink),
      .state     (state)
   );

   // stim: {reset_n, reset_btn, pause_btn, sel, adj, tick_run, tick_adj, tick_blink}
   // expv: {clr, inc_sec, inc_min, adj_mode, blink, state[1:0]}
   typedef struct {
      logic [7:0] stim;
      logic [6:0] expv;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [7:0] s, input logic [6:0] e);
      vec_t v;
      v.stim = s;
      v.expv = e;
      return v;
   endfunction

   task automatic drive(input logic [7:0] s);
      {reset_n, reset_btn, pause_btn, sel, adj, tick_run, tick_adj, tick_blink} = s;
   endtask

   task automatic check(input string name, input int idx, input logic [6:0] got,
                        input logic [6:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s %0d: got %b expected %b", name, idx, got, exp_v);
      end
   endtask

   initial begin
      int pulses;
      logic [6:0] got;

      drive(8'b0000_0000);
`ifdef STOPWATCH_LAP_EN
      lap_btn = 1'b0;
`endif
      // Reset, then idle ticks give nothing.
      vecs.push_back(mk(8'b0_0_0_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b0_0_0_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_00));
      // Pause edge starts RUN, three ticks -> three inc_sec.
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_01));
      vecs.push_back(mk(8'b1_0_1_0_0_1_0_0, 7'b0_1_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_1_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_1_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_01));
      // Pause edge with tick: increment and transition both; paused ticks ignored.
      vecs.push_back(mk(8'b1_0_1_0_0_1_0_0, 7'b0_1_0_0_1_10));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_10));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_0_0_0_1_10));
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_01));
      // Adjust minutes from RUN, every 2nd tick_adj increments, blink per tick_blink.
      vecs.push_back(mk(8'b1_0_0_0_1_0_0_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_1_0_1_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_1_0_1_0, 7'b0_0_1_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_1_0_1_1, 7'b0_0_0_1_0_11));
      vecs.push_back(mk(8'b1_0_0_0_1_0_1_0, 7'b0_0_1_1_0_11));
      vecs.push_back(mk(8'b1_0_0_0_1_1_1_1, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_1_0_1_0, 7'b0_0_1_1_1_11));
      // sel flips mid-divide: next increment goes to seconds, divider keeps its count.
      vecs.push_back(mk(8'b1_0_0_0_1_0_1_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_1_1_0_1_1, 7'b0_1_0_1_0_11));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_01));
      // Adjust entered from PAUSED, pause edge inside flips resume target to RUN.
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_10));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_10));
      vecs.push_back(mk(8'b1_0_0_0_1_0_0_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_1_0_1_0_0_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_1_0_0_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_0_1_0_0, 7'b0_1_0_0_1_01));
      // reset_btn + pause_btn + tick in RUN: clear only, go IDLE.
      vecs.push_back(mk(8'b1_1_1_0_0_1_0_0, 7'b1_0_0_0_1_00));
      vecs.push_back(mk(8'b1_1_1_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_1_0_0_1_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_00));
      // pause_btn held across a reset_n pulse: no edge after release.
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_01));
      vecs.push_back(mk(8'b0_0_1_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_00));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_00));
      // reset_btn while adj held: clear, stay ADJUST, then exit to PAUSED (run_flag cleared).
      vecs.push_back(mk(8'b1_0_1_0_0_0_0_0, 7'b0_0_0_0_1_01));
      vecs.push_back(mk(8'b1_0_0_0_1_0_0_0, 7'b0_0_0_1_1_11));
      vecs.push_back(mk(8'b1_1_0_0_1_0_1_0, 7'b1_0_0_1_1_11));
      vecs.push_back(mk(8'b1_0_0_0_0_0_0_0, 7'b0_0_0_0_1_10));

      foreach (vecs[i]) begin
         drive(vecs[i].stim);
         @(posedge clk);
         #1;
         got = {clr, inc_sec, inc_min, adj_mode, blink, state};
         check("vec", i, got, vecs[i].expv);
      end

      // Back to RUN, ticks every other cycle: each inc_sec follows its tick by one clock.
      drive(8'b1_0_1_0_0_0_0_0);
      @(posedge clk);
      #1;
      check("resume_state", 0, {5'b0, state}, {5'b0, 2'b01});
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick_run = (k % 2 == 0);
         @(posedge clk);
         #1;
         if (inc_sec === 1'b1) pulses++;
         check("run_pulse", k, {6'b0, inc_sec}, {6'b0, (k % 2 == 0)});
      end
      tick_run = 1'b0;
      check("run_pulse_count", pulses, 7'(pulses), 7'd4);

`ifdef STOPWATCH_LAP_EN
      // Lap edge in RUN freezes display while counting continues; pause clears freeze.
      pause_btn = 1'b0;
      lap_btn   = 1'b1;
      tick_run  = 1'b1;
      @(posedge clk);
      #1;
      check("lap_freeze", 0, {4'b0, freeze, inc_sec, state == 2'b01}, 7'b000_0111);
      lap_btn = 1'b0;
      @(posedge clk);
      #1;
      check("lap_count", 1, {4'b0, freeze, inc_sec, state == 2'b01}, 7'b000_0111);
      tick_run  = 1'b0;
      pause_btn = 1'b1;
      @(posedge clk);
      #1;
      check("lap_pause", 2, {4'b0, freeze, state}, 7'b000_0010);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
Single-clock control FSM that sequences the stopwatch time counter. It takes debounced button/switch levels and divider tick strobes, and issues one-cycle clear/increment commands plus display mode flags (adjust, blink). It sits between the debouncers/clock divider and the MM:SS counter/display mux, and replaces derived-clock sequencing with clock-enable strobes on the main clock.

Parameters:
AUTO_START, 0, 1: leave reset in RUN instead of IDLE
ADJ_DIV, 1, number of tick_adj strobes per adjust increment (1..15)
BLINK_DIV, 1, number of tick_blink strobes per blink toggle (1..15)

Ports:
clk  in  1  main clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
reset_btn  in  1  debounced reset button level
pause_btn  in  1  debounced pause button level
sel  in  1  adjust target: 0 = minutes, 1 = seconds
adj  in  1  adjust switch level
tick_run  in  1  one-cycle 1 Hz strobe
tick_adj  in  1  one-cycle 2 Hz strobe
tick_blink  in  1  one-cycle blink-rate strobe
clr  out  1  one-cycle clear command to counter
inc_sec  out  1  one-cycle seconds increment (counter handles carry)
inc_min  out  1  one-cycle minutes increment, no carry into seconds
adj_mode  out  1  high in ADJUST
blink  out  1  display enable for selected field; 1 outside ADJUST
state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 ADJUST

Behaviour:
- Edge detect: rising edges of reset_btn/pause_btn via prev registers; during reset the prev registers load the current input, so a button held across reset yields no edge.
- Reset (reset_n=0 at edge): state=IDLE (RUN if AUTO_START), run_flag=AUTO_START, clr=1 on first cycle after reset release is NOT issued; clr/inc_sec/inc_min=0, adj_mode=0, blink=1, divider counters=0.
- All outputs registered; command latency = 1 clk after causing input.
- Priority each cycle: reset_btn edge > adj level > pause_btn edge > ticks.
- reset_btn edge, any state: clr=1 next cycle, run_flag=0, dividers cleared; state=IDLE, or ADJUST if adj=1.
- adj=1 from IDLE/RUN/PAUSED: ADJUST next cycle; run_flag keeps its value; adjust divider and blink phase restart (blink=1).
- ADJUST: each ADJ_DIV-th tick_adj -> inc_sec (sel=1) or inc_min (sel=0); tick_run ignored; pause edge toggles run_flag only; each BLINK_DIV-th tick_blink toggles blink.
- ADJUST, adj=0: state=RUN if run_flag else PAUSED; blink=1, adj_mode=0 next cycle.
- pause edge: IDLE->RUN, RUN->PAUSED, PAUSED->RUN; run_flag tracks RUN.
- RUN: tick_run -> inc_sec. tick_run coincident with pause edge: increment issued AND transition taken.
- IDLE/PAUSED: ticks produce no commands.
- inc_sec and inc_min never both high; clr never coincides with an inc.
- sel change mid-ADJUST applies to next increment; divider is not reset.

Optional Feature:
STOPWATCH_LAP_EN. Defined: extra input lap_btn (1) and output freeze (1, reset 0). lap_btn rising edge in RUN toggles freeze; freeze tells display to hold its last value while counting continues. Freeze cleared by reset_btn edge, entering ADJUST, or leaving RUN. Undefined: no lap_btn/freeze ports; display always live.

Test Plan:
- Reset release, AUTO_START=0, 5 tick_run -> state=00, no inc_sec; pause edge, 3 tick_run -> exactly 3 inc_sec pulses, each 1 clk after tick.
- RUN, pause edge and tick_run same cycle -> one inc_sec, state=10 next cycle; further ticks -> no commands.
- RUN, adj=1, sel=0, ADJ_DIV=2, 6 tick_adj -> 3 inc_min, 0 inc_sec, state=11; blink toggles per tick_blink; adj=0 -> state=01, blink=1.
- ADJUST from PAUSED, pause edge, adj=0 -> state=01 (run_flag toggled).
- reset_btn and pause_btn rise same cycle in RUN -> clr=1 for one cycle, state=00; pause_btn held through reset_n pulse -> no transition after release.
- STOPWATCH_LAP_EN: RUN, lap edge -> freeze=1, inc_sec continues; pause edge -> state=10, freeze=0.
